// File: rtl/branch_pkg.sv
// Shared encodings for the branch unit: func3 codes, 2-bit counter states, FSM states.
package branch_pkg;

   localparam logic [2:0] BEQ  = 3'b000;
   localparam logic [2:0] BNE  = 3'b001;
   localparam logic [2:0] BLT  = 3'b100;
   localparam logic [2:0] BGE  = 3'b101;
   localparam logic [2:0] BLTU = 3'b110;
   localparam logic [2:0] BGEU = 3'b111;

   localparam logic [1:0] SNT = 2'b00;
   localparam logic [1:0] WNT = 2'b01;
   localparam logic [1:0] WT  = 2'b10;
   localparam logic [1:0] ST  = 2'b11;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/branch_cond.sv
// Combinational branch condition decode: func3 plus ALU compare flags to taken/illegal.
module branch_cond
   import branch_pkg::*;
(
   input  logic [2:0] branch_op,
   input  logic       equ,
   input  logic       lt,
   input  logic       ltu,
   output logic       taken,
   output logic       err
);

   always_comb begin
      taken = 1'b0;
      err   = 1'b0;
      case (branch_op)
         BEQ:     taken = equ;
         BNE:     taken = !equ;
         BLT:     taken = lt;
         BGE:     taken = equ | !lt;
         BLTU:    taken = ltu;
         BGEU:    taken = equ | !ltu;
         default: err   = 1'b1;
      endcase
   end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch resolve unit with a 2-bit saturating-counter BHT predictor.
// Define BRANCH_STATS_EN to add branch / mispredict statistics counters.
module branch_predict_unit
   import branch_pkg::*;
#(
   parameter int         XLEN      = 32,
   parameter int         BHT_DEPTH = 64,
   parameter logic [1:0] CNT_INIT  = 2'b01
) (
   input  logic            clk_i,
   input  logic            rst_i,
   output logic            ready_o,
   input  logic            fetch_valid_i,
   input  logic [XLEN-1:0] fetch_pc_i,
   output logic            predict_valid_o,
   output logic            predict_taken_o,
   input  logic            ex_valid_i,
   input  logic [XLEN-1:0] ex_pc_i,
   input  logic [2:0]      branch_op_i,
   input  logic            equ_i,
   input  logic            lt_i,
   input  logic            ltu_i,
   input  logic            ex_pred_taken_i,
   output logic            resolve_valid_o,
   output logic            is_branch_taken_o,
   output logic            mispredict_o,
   output logic            branch_err_o
`ifdef BRANCH_STATS_EN
   ,
   output logic [31:0]     stat_branches_o,
   output logic [31:0]     stat_mispredicts_o
`endif
);

   localparam int IDX_W = $clog2(BHT_DEPTH);

   state_t           state;
   logic [IDX_W-1:0] init_cnt;
   logic [IDX_W-1:0] fetch_idx;
   logic [IDX_W-1:0] ex_idx;
   logic [1:0]       bht [BHT_DEPTH];
   logic             cond_taken;
   logic             cond_err;
   logic             pc_unused;

   logic ready_p1;
   logic predict_valid_p1;
   logic predict_taken_p1;
   logic resolve_valid_p1;
   logic taken_p1;
   logic mispredict_p1;
   logic err_p1;

   function automatic logic [1:0] sat_step(input logic [1:0] cnt, input logic up);
      if (up)
         return (cnt == ST) ? ST : cnt + 2'd1;
      else
         return (cnt == SNT) ? SNT : cnt - 2'd1;
   endfunction

   assign fetch_idx = fetch_pc_i[2 +: IDX_W];
   assign ex_idx    = ex_pc_i[2 +: IDX_W];
   assign pc_unused = ^{fetch_pc_i[XLEN-1:2+IDX_W], fetch_pc_i[1:0],
                        ex_pc_i[XLEN-1:2+IDX_W], ex_pc_i[1:0]};

   branch_cond u_cond (
      .branch_op (branch_op_i),
      .equ       (equ_i),
      .lt        (lt_i),
      .ltu       (ltu_i),
      .taken     (cond_taken),
      .err       (cond_err)
   );

   // FSM: INIT sweeps every BHT entry once, then RUN
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state    <= INIT;
         init_cnt <= '0;
         ready_p1 <= 1'b0;
      end else begin
         case (state)
            INIT: begin
               init_cnt <= init_cnt + 1'b1;
               if (init_cnt == IDX_W'(BHT_DEPTH - 1)) begin
                  state    <= RUN;
                  ready_p1 <= 1'b1;
               end
            end
            RUN: ;
            default: state <= INIT;
         endcase
      end
   end

   // BHT write port; the registered lookup below reads the pre-update value
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         if (state == INIT)
            bht[init_cnt] <= CNT_INIT;
         else if (ex_valid_i && !cond_err)
            bht[ex_idx] <= sat_step(bht[ex_idx], cond_taken);
      end
   end

   // Stage p1: lookup and resolve output registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         predict_valid_p1 <= 1'b0;
         predict_taken_p1 <= 1'b0;
         resolve_valid_p1 <= 1'b0;
         taken_p1         <= 1'b0;
         mispredict_p1    <= 1'b0;
         err_p1           <= 1'b0;
      end else begin
         predict_valid_p1 <= fetch_valid_i;
         predict_taken_p1 <= (state == RUN) && bht[fetch_idx][1];
         resolve_valid_p1 <= ex_valid_i;
         taken_p1         <= ex_valid_i && cond_taken;
         err_p1           <= ex_valid_i && cond_err;
         mispredict_p1    <= ex_valid_i && !cond_err && (cond_taken ^ ex_pred_taken_i);
      end
   end

   assign ready_o           = ready_p1;
   assign predict_valid_o   = predict_valid_p1;
   assign predict_taken_o   = predict_taken_p1;
   assign resolve_valid_o   = resolve_valid_p1;
   assign is_branch_taken_o = taken_p1;
   assign mispredict_o      = mispredict_p1;
   assign branch_err_o      = err_p1;

`ifdef BRANCH_STATS_EN
   logic [31:0] stat_branches_p2;
   logic [31:0] stat_mispredicts_p2;

   // Stage p2: statistics count the presented resolve pulses
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stat_branches_p2    <= '0;
         stat_mispredicts_p2 <= '0;
      end else begin
         if (resolve_valid_p1 && !err_p1)
            stat_branches_p2 <= stat_branches_p2 + 32'd1;
         if (mispredict_p1)
            stat_mispredicts_p2 <= stat_mispredicts_p2 + 32'd1;
      end
   end

   assign stat_branches_o    = stat_branches_p2;
   assign stat_mispredicts_o = stat_mispredicts_p2;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Scoreboard bench for branch_predict_unit: random and directed stimulus vs. a behavioural model.
module tb_branch_predict_unit;
   import branch_pkg::*;

   localparam int DEPTH = 64;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ready;
   logic        fetch_valid = 1'b0;
   logic [31:0] fetch_pc = '0;
   logic        predict_valid;
   logic        predict_taken;
   logic        ex_valid = 1'b0;
   logic [31:0] ex_pc = '0;
   logic [2:0]  branch_op = '0;
   logic        equ = 1'b0;
   logic        lt = 1'b0;
   logic        ltu = 1'b0;
   logic        ex_pred_taken = 1'b0;
   logic        resolve_valid;
   logic        is_taken;
   logic        mispredict;
   logic        branch_err;
`ifdef BRANCH_STATS_EN
   logic [31:0] stat_branches;
   logic [31:0] stat_mispredicts;
   int          n_br = 0;
   int          n_mp = 0;
`endif

   always #5 clk = ~clk;

   branch_predict_unit #(.XLEN(32), .BHT_DEPTH(DEPTH), .CNT_INIT(2'b01)) dut (
      .clk_i             (clk),
      .rst_i             (rst),
      .ready_o           (ready),
      .fetch_valid_i     (fetch_valid),
      .fetch_pc_i        (fetch_pc),
      .predict_valid_o   (predict_valid),
      .predict_taken_o   (predict_taken),
      .ex_valid_i        (ex_valid),
      .ex_pc_i           (ex_pc),
      .branch_op_i       (branch_op),
      .equ_i             (equ),
      .lt_i              (lt),
      .ltu_i             (ltu),
      .ex_pred_taken_i   (ex_pred_taken),
      .resolve_valid_o   (resolve_valid),
      .is_branch_taken_o (is_taken),
      .mispredict_o      (mispredict),
      .branch_err_o      (branch_err)
`ifdef BRANCH_STATS_EN
      ,
      .stat_branches_o   (stat_branches),
      .stat_mispredicts_o(stat_mispredicts)
`endif
   );

   int       total = 0;
   int       bad = 0;
   int       bht_m [DEPTH];
   int       init_left = DEPTH;
   bit       exp_ready = 1'b0;
   bit       mon_en = 1'b0;
   bit       pred_q [$];
   bit [2:0] res_q [$];
   bit       mon_p;
   bit [2:0] mon_r;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic int idx_of(input logic [31:0] pc);
      return int'((pc >> 2) % DEPTH);
   endfunction

   // Expected outcome from the compare flags
   task automatic flag_taken(input logic [2:0] op, input bit e, input bit l, input bit lu,
                             output bit xt, output bit xe);
      xe = 1'b0;
      case (op)
         BEQ:     xt = e;
         BNE:     xt = !e;
         BLT:     xt = l;
         BGE:     xt = e || !l;
         BLTU:    xt = lu;
         BGEU:    xt = e || !lu;
         default: begin xt = 1'b0; xe = 1'b1; end
      endcase
   endtask

   // Random operands; expected outcome taken from the operand values directly
   task automatic rand_branch(output logic [2:0] op, output bit e, output bit l, output bit lu,
                              output bit xt, output bit xe);
      logic [31:0] a, b;
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
      op = 3'($urandom_range(0, 7));
      e  = (a == b);
      l  = ($signed(a) < $signed(b));
      lu = (a < b);
      xe = 1'b0;
      case (op)
         BEQ:     xt = (a == b);
         BNE:     xt = (a != b);
         BLT:     xt = ($signed(a) < $signed(b));
         BGE:     xt = ($signed(a) >= $signed(b));
         BLTU:    xt = (a < b);
         BGEU:    xt = (a >= b);
         default: begin xt = 1'b0; xe = 1'b1; end
      endcase
   endtask

   // One clock cycle of stimulus; the model predicts responses and advances its state
   task automatic cyc(input bit r, input bit fv, input logic [31:0] fpc,
                      input bit ev, input logic [31:0] epc, input logic [2:0] op,
                      input bit e, input bit l, input bit lu, input bit pt,
                      input bit xt, input bit xe);
      int i;
      rst = r; fetch_valid = fv; fetch_pc = fpc; ex_valid = ev; ex_pc = epc;
      branch_op = op; equ = e; lt = l; ltu = lu; ex_pred_taken = pt;
      if (!r) begin
         if (fv)
            pred_q.push_back((init_left == 0) ? (bht_m[idx_of(fpc)] >= 2) : 1'b0);
         if (ev) begin
            res_q.push_back({xt, (!xe && (xt != pt)), xe});
`ifdef BRANCH_STATS_EN
            if (!xe) n_br++;
            if (!xe && (xt != pt)) n_mp++;
`endif
            if (init_left == 0 && !xe) begin
               i = idx_of(epc);
               bht_m[i] = xt ? ((bht_m[i] < 3) ? bht_m[i] + 1 : 3)
                             : ((bht_m[i] > 0) ? bht_m[i] - 1 : 0);
            end
         end
      end
      @(posedge clk);
      #1;
      if (r) begin
         init_left = DEPTH;
`ifdef BRANCH_STATS_EN
         n_br = 0;
         n_mp = 0;
`endif
      end else if (init_left > 0) begin
         init_left--;
         if (init_left == 0)
            foreach (bht_m[k]) bht_m[k] = 1;
      end
      exp_ready = (init_left == 0);
   endtask

   task automatic look(input logic [31:0] pc);
      cyc(1'b0, 1'b1, pc, 1'b0, '0, BEQ, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic br(input logic [31:0] pc, input logic [2:0] op, input bit e, input bit l,
                     input bit lu, input bit pt, input bit fv, input logic [31:0] fpc);
      bit xt, xe;
      flag_taken(op, e, l, lu, xt, xe);
      cyc(1'b0, fv, fpc, 1'b1, pc, op, e, l, lu, pt, xt, xe);
   endtask

   task automatic rand_cycle(input bit fv, input logic [31:0] fpc, input bit ev, input logic [31:0] epc);
      logic [2:0] op;
      bit e, l, lu, xt, xe;
      rand_branch(op, e, l, lu, xt, xe);
      cyc(1'b0, fv, fpc, ev, epc, op, e, l, lu, 1'($urandom_range(0, 1)), xt, xe);
   endtask

   function automatic logic [31:0] pick_pc();
      case ($urandom_range(0, 3))
         0:       return 32'h40;
         1:       return 32'h140;
         2:       return 32'h44;
         default: return {$urandom} & 32'hfffc;
      endcase
   endfunction

   // Monitor: pops the scoreboard whenever the DUT presents an output
   always @(negedge clk) begin
      if (mon_en) begin
         check("ready", ready, exp_ready);
         if (predict_valid) begin
            if (pred_q.size() == 0)
               check("pred_unexpected", predict_valid, 1'b0);
            else begin
               mon_p = pred_q.pop_front();
               check("pred_taken", predict_taken, mon_p);
            end
         end
         if (resolve_valid) begin
            if (res_q.size() == 0)
               check("resolve_unexpected", resolve_valid, 1'b0);
            else begin
               mon_r = res_q.pop_front();
               check("resolve_taken_misp_err", {is_taken, mispredict, branch_err}, mon_r);
            end
         end else begin
            check("resolve_idle_zero", {is_taken, mispredict, branch_err}, 3'b000);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit e, l, lu;
      foreach (bht_m[k]) bht_m[k] = 1;

      // Reset and init sweep with lookups and resolves in flight
      cyc(1'b1, 1'b0, '0, 1'b0, '0, BEQ, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      mon_en = 1'b1;
      for (int i = 0; i < DEPTH; i++)
         rand_cycle(1'b1, pick_pc(), 1'($urandom_range(0, 1)), pick_pc());

      // Each func3 against the four flag patterns
      for (int op = 0; op < 8; op++) begin
         for (int p = 0; p < 4; p++) begin
            e = (p == 0); l = (p == 1); lu = (p == 2);
            br(32'h1000 + 32'(op * 4), 3'(op), e, l, lu, 1'($urandom_range(0, 1)),
               1'b1, 32'h1000 + 32'(p * 4));
         end
      end

      // Saturation on pc 0x40, illegal func3 leaves the counter alone
      for (int i = 0; i < 4; i++) br(32'h40, BEQ, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
      look(32'h40);
      br(32'h40, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h40);
      br(32'h40, 3'b011, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h40);
      for (int i = 0; i < 4; i++) br(32'h40, BEQ, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h40);
      look(32'h40);
      br(32'h40, BEQ, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h40);
      br(32'h40, BEQ, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h40);
      look(32'h40);

      // Mispredict on BNE with equal operands
      br(32'h80, BNE, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0);

      // Alias 0x140 updates idx 16 while 0x40 looks it up
      br(32'h140, BEQ, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h40);
      look(32'h40);

      for (int i = 0; i < 400; i++)
         rand_cycle(1'($urandom_range(0, 1)), pick_pc(), 1'($urandom_range(0, 1)), pick_pc());

      // Reset in the middle of a resolve
      br(32'h40, BEQ, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h40);
      cyc(1'b1, 1'b1, 32'h40, 1'b1, 32'h40, BEQ, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
`ifdef BRANCH_STATS_EN
      check("stat_branches_reset", stat_branches, 32'd0);
      check("stat_mispredicts_reset", stat_mispredicts, 32'd0);
`endif
      for (int i = 0; i < DEPTH; i++)
         rand_cycle(1'b1, pick_pc(), 1'($urandom_range(0, 1)), pick_pc());
      for (int i = 0; i < 8; i++) begin
         br(32'h200 + 32'(i * 4), BEQ, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h200 + 32'(i * 4));
         look(32'h200 + 32'(i * 4));
      end

      for (int i = 0; i < 3; i++)
         cyc(1'b0, 1'b0, '0, 1'b0, '0, BEQ, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef BRANCH_STATS_EN
      check("stat_branches", stat_branches, 32'(n_br));
      check("stat_mispredicts", stat_mispredicts, 32'(n_mp));
`endif
      check("pred_queue_drained", 32'(pred_q.size()), 32'd0);
      check("resolve_queue_drained", 32'(res_q.size()), 32'd0);
      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
